// File: rtl/btb_assoc_file_if.sv
// Lookup, update and flush signal bundle for the set-associative BTB.
// master = fetch/execute side driving requests, slave = the BTB array.
interface btb_assoc_file_if #(
  parameter int PC_W     = 32,
  parameter int TARGET_W = 32
);
  logic                lookup_valid;
  logic [PC_W-1:0]     lookup_pc;
  logic                pred_valid;
  logic                pred_hit;
  logic [TARGET_W-1:0] pred_target;
  logic                pred_taken;
  logic                upd_valid;
  logic                upd_ready;
  logic [PC_W-1:0]     upd_pc;
  logic [TARGET_W-1:0] upd_target;
  logic                upd_taken;
  logic                flush_req;
  logic                flush_busy;

  modport master (
    output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, flush_req,
    input  pred_valid, pred_hit, pred_target, pred_taken, upd_ready, flush_busy
  );

  modport slave (
    input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, flush_req,
    output pred_valid, pred_hit, pred_target, pred_taken, upd_ready, flush_busy
  );
endinterface

// File: rtl/btb_assoc_file.sv
// Set-associative branch target buffer: registered lookup with write-first
// forwarding of a same-cycle update, saturating 2-bit direction counters,
// tree-PLRU replacement and a one-set-per-cycle flush sequencer.
module btb_assoc_file #(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int PC_W     = 32,
  parameter int TARGET_W = 32
) (
  input logic             clk,
  input logic             rst_n,
  btb_assoc_file_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef enum logic {IDLE, FLUSH} state_t;
  // Way numbers are carried as 2 bits regardless of WAYS (max 4 ways).
  typedef logic [1:0] way_t;

  // PLRU helpers; bits above what WAYS needs stay at zero.
  function automatic way_t plru_victim(input logic [2:0] b);
    way_t v;
    if (WAYS == 4)      v = b[0] ? (b[2] ? 2'd3 : 2'd2) : (b[1] ? 2'd1 : 2'd0);
    else if (WAYS == 2) v = {1'b0, b[0]};
    else                v = 2'd0;
    return v;
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input way_t w);
    logic [2:0] r;
    r = b;
    if (WAYS == 4) begin
      r[0] = ~w[1];
      if (!w[1]) r[1] = ~w[0];
      else       r[2] = ~w[0];
    end else if (WAYS == 2) begin
      r[0] = ~w[0];
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  // ---------------- state ----------------
  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               flush_idx_q;
  logic [SETS-1:0][WAYS-1:0]      valid_q;
  logic [SETS-1:0][WAYS-1:0][1:0] cnt_q;
  logic [SETS-1:0][2:0]           plru_q;
  logic [TAG_W-1:0]               tag_q [SETS][WAYS];
  logic [TARGET_W-1:0]            tgt_q [SETS][WAYS];

  logic                pred_valid_q, pred_hit_q, pred_taken_q;
  logic [TARGET_W-1:0] pred_target_q;

  // ---------------- update side ----------------
  logic             upd_fire, u_hit, u_inv, u_write;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  way_t             u_hit_way, u_inv_way, u_way;
  logic [1:0]       u_cur_cnt, u_cnt_new;
  logic [2:0]       u_plru_new;

  assign upd_fire = bus.upd_valid && bus.upd_ready;
  assign u_idx    = bus.upd_pc[IDX_W+1:2];
  assign u_tag    = bus.upd_pc[PC_W-1:IDX_W+2];

  // Tag match / free-way search in the update set; descending loop so the
  // lowest matching or invalid way wins. Then the new counter and PLRU.
  always_comb begin
    u_hit     = 1'b0;
    u_hit_way = '0;
    u_inv     = 1'b0;
    u_inv_way = '0;
    u_cur_cnt = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
        u_hit     = 1'b1;
        u_hit_way = way_t'(w);
        u_cur_cnt = cnt_q[u_idx][w];
      end
      if (!valid_q[u_idx][w]) begin
        u_inv     = 1'b1;
        u_inv_way = way_t'(w);
      end
    end
    u_way = u_hit ? u_hit_way : (u_inv ? u_inv_way : plru_victim(plru_q[u_idx]));
    if (!u_hit)             u_cnt_new = 2'b10;
    else if (bus.upd_taken) u_cnt_new = (u_cur_cnt == 2'd3) ? 2'd3 : u_cur_cnt + 2'd1;
    else                    u_cnt_new = (u_cur_cnt == 2'd0) ? 2'd0 : u_cur_cnt - 2'd1;
    // A not-taken miss leaves the array untouched.
    u_write    = upd_fire && (u_hit || bus.upd_taken);
    u_plru_new = plru_touch(plru_q[u_idx], u_way);
  end

  // ---------------- lookup side ----------------
  logic [IDX_W-1:0]    l_idx;
  logic [TAG_W-1:0]    l_tag;
  logic                l_hit;
  logic [TARGET_W-1:0] l_tgt;
  logic [1:0]          l_cnt;

  assign l_idx = bus.lookup_pc[IDX_W+1:2];
  assign l_tag = bus.lookup_pc[PC_W-1:IDX_W+2];

  // Lookup sees the way being written this cycle with its post-update
  // contents (write-first); other ways read the stored array.
  always_comb begin
    logic             fwd;
    logic             e_vld;
    logic [TAG_W-1:0] e_tag;
    fwd   = 1'b0;
    e_vld = 1'b0;
    e_tag = '0;
    l_hit = 1'b0;
    l_tgt = '0;
    l_cnt = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      fwd   = u_write && (u_idx == l_idx) && (u_way == way_t'(w));
      e_vld = fwd || valid_q[l_idx][w];
      e_tag = fwd ? u_tag : tag_q[l_idx][w];
      if (e_vld && e_tag == l_tag) begin
        l_hit = 1'b1;
        l_tgt = fwd ? bus.upd_target : tgt_q[l_idx][w];
        l_cnt = fwd ? u_cnt_new : cnt_q[l_idx][w];
      end
    end
  end

  // ---------------- flush FSM ----------------
  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: flush_req only starts a sweep from IDLE; the sweep ends after
  // the last set has been cleared.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.flush_req) state_d = FLUSH;
      FLUSH:   if (flush_idx_q == IDX_W'(SETS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flush set pointer; SETS is a power of two so it wraps back to 0 itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                flush_idx_q <= '0;
    else if (state_q == FLUSH) flush_idx_q <= flush_idx_q + 1'b1;
    else                       flush_idx_q <= '0;
  end

  assign bus.flush_busy = (state_q == FLUSH);
  assign bus.upd_ready  = (state_q == IDLE);

  // ---------------- array writes ----------------
  // Valid/counter/PLRU state: cleared by reset, swept by flush, written by
  // updates (updates are never accepted while flushing).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      cnt_q   <= '0;
      plru_q  <= '0;
    end else if (state_q == FLUSH) begin
      valid_q[flush_idx_q] <= '0;
      plru_q[flush_idx_q]  <= '0;
    end else if (u_write) begin
      for (int w = 0; w < WAYS; w++) begin
        if (u_way == way_t'(w)) begin
          valid_q[u_idx][w] <= 1'b1;
          cnt_q[u_idx][w]   <= u_cnt_new;
        end
      end
      plru_q[u_idx] <= u_plru_new;
    end
  end

  // Tag and target payload; qualified by valid, so no reset needed.
  always_ff @(posedge clk) begin
    if (u_write) begin
      for (int w = 0; w < WAYS; w++) begin
        if (u_way == way_t'(w)) begin
          tag_q[u_idx][w] <= u_tag;
          tgt_q[u_idx][w] <= bus.upd_target;
        end
      end
    end
  end

  // ---------------- prediction register ----------------
  // One-cycle lookup result; lookups sampled mid-flush always miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_target_q <= '0;
      pred_taken_q  <= 1'b0;
    end else begin
      pred_valid_q  <= bus.lookup_valid;
      pred_hit_q    <= bus.lookup_valid && l_hit && (state_q == IDLE);
      pred_target_q <= (bus.lookup_valid && l_hit && (state_q == IDLE)) ? l_tgt : '0;
      pred_taken_q  <= bus.lookup_valid && l_hit && (state_q == IDLE) && l_cnt[1];
    end
  end

  assign bus.pred_valid  = pred_valid_q;
  assign bus.pred_hit    = pred_hit_q;
  assign bus.pred_target = pred_target_q;
  assign bus.pred_taken  = pred_taken_q;

  // Byte-offset PC bits carry no information for the BTB.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};
endmodule

// File: tb/tb_btb_assoc_file.sv
// Directed bench for btb_assoc_file (SETS=8, WAYS=2): expected predictions
// are queued when a lookup is driven and checked when pred_valid appears.
module tb_btb_assoc_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btb_assoc_file_if #(.PC_W(32), .TARGET_W(32)) bus ();

  btb_assoc_file #(.SETS(8), .WAYS(2), .PC_W(32), .TARGET_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic        hit;
    logic [31:0] tgt;
    logic        tk;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected prediction, step, check.
  task automatic cyc(input logic lv, input logic [31:0] lpc,
                     input logic eh, input logic [31:0] et, input logic ek,
                     input logic uv, input logic [31:0] upc,
                     input logic [31:0] ut, input logic uk, input logic fr);
    exp_t e;
    bus.lookup_valid = lv;
    bus.lookup_pc    = lpc;
    bus.upd_valid    = uv;
    bus.upd_pc       = upc;
    bus.upd_target   = ut;
    bus.upd_taken    = uk;
    bus.flush_req    = fr;
    if (lv) sb.push_back('{hit: eh, tgt: et, tk: ek});
    @(posedge clk);
    #1;
    bus.lookup_valid = 1'b0;
    bus.upd_valid    = 1'b0;
    bus.flush_req    = 1'b0;
    chk("pred_valid", 32'(bus.pred_valid), 32'(lv));
    if (bus.pred_valid) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("hit@%0h", lpc), 32'(bus.pred_hit), 32'(e.hit));
        chk($sformatf("target@%0h", lpc), bus.pred_target, e.tgt);
        chk($sformatf("taken@%0h", lpc), 32'(bus.pred_taken), 32'(e.tk));
      end
    end
  endtask

  task automatic lk(input logic [31:0] pc, input logic eh, input logic [31:0] et, input logic ek);
    cyc(1'b1, pc, eh, et, ek, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic up(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, pc, tgt, tk, 1'b0);
  endtask

  task automatic chk_fl(input logic busy);
    chk("flush_busy", 32'(bus.flush_busy), 32'(busy));
    chk("upd_ready", 32'(bus.upd_ready), 32'(!busy));
  endtask

  // Async reset pulse; outputs must clear without waiting for a clock.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
    chk("rst_pred_hit", 32'(bus.pred_hit), 32'd0);
    chk("rst_pred_target", bus.pred_target, 32'd0);
    chk("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
    chk("rst_flush_busy", 32'(bus.flush_busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_upd_ready", 32'(bus.upd_ready), 32'd1);
  endtask

  initial begin
    bus.lookup_valid = 1'b0;
    bus.lookup_pc    = '0;
    bus.upd_valid    = 1'b0;
    bus.upd_pc       = '0;
    bus.upd_target   = '0;
    bus.upd_taken    = 1'b0;
    bus.flush_req    = 1'b0;

    // power-on reset
    pulse_reset();
    lk(32'h100, 1'b0, 32'h0, 1'b0);

    // allocate, then counter walk incl. saturation at 0 and 3
    up(32'h100, 32'h200, 1'b1);                // cnt 2
    lk(32'h100, 1'b1, 32'h200, 1'b1);
    up(32'h100, 32'h200, 1'b0);                // 1
    up(32'h100, 32'h200, 1'b0);                // 0
    lk(32'h100, 1'b1, 32'h200, 1'b0);
    up(32'h100, 32'h200, 1'b0);                // stays 0
    up(32'h100, 32'h200, 1'b1);                // 1
    lk(32'h100, 1'b1, 32'h200, 1'b0);
    up(32'h100, 32'h200, 1'b1);                // 2
    up(32'h100, 32'h200, 1'b1);                // 3
    up(32'h100, 32'h200, 1'b1);                // stays 3
    lk(32'h100, 1'b1, 32'h200, 1'b1);
    up(32'h100, 32'h200, 1'b0);                // 2
    lk(32'h100, 1'b1, 32'h200, 1'b1);
    up(32'h100, 32'h200, 1'b0);                // 1
    lk(32'h100, 1'b1, 32'h200, 1'b0);

    // replacement in set 0: A=0x100 (way0), B=0x200 (way1), touch A, C evicts B
    up(32'h200, 32'h2B0, 1'b1);
    up(32'h100, 32'h204, 1'b1);                // hit: new target, cnt 1->2
    up(32'h300, 32'h3C0, 1'b1);
    lk(32'h100, 1'b1, 32'h204, 1'b1);
    lk(32'h200, 1'b0, 32'h0, 1'b0);
    lk(32'h300, 1'b1, 32'h3C0, 1'b1);

    // same-cycle forwarding, and a different set left alone
    cyc(1'b1, 32'h108, 1'b1, 32'h888, 1'b1, 1'b1, 32'h108, 32'h888, 1'b1, 1'b0);
    cyc(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10C, 32'h999, 1'b1, 1'b0);
    lk(32'h10C, 1'b1, 32'h999, 1'b1);

    // not-taken miss does not allocate
    up(32'h110, 32'h555, 1'b0);
    lk(32'h110, 1'b0, 32'h0, 1'b0);

    // reset mid-run while a hit is displayed
    lk(32'h10C, 1'b1, 32'h999, 1'b1);
    pulse_reset();
    lk(32'h10C, 1'b0, 32'h0, 1'b0);
    lk(32'h300, 1'b0, 32'h0, 1'b0);

    // flush: 8 busy cycles, update with flush_req commits then is swept,
    // lookups and updates during the sweep do nothing, re-request ignored
    up(32'h108, 32'h888, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h114, 32'h777, 1'b1, 1'b1);
    chk_fl(1'b1);
    lk(32'h108, 1'b0, 32'h0, 1'b0);
    chk_fl(1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h118, 32'h666, 1'b1, i == 1);
      chk_fl(1'b1);
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk_fl(1'b0);
    lk(32'h108, 1'b0, 32'h0, 1'b0);
    lk(32'h114, 1'b0, 32'h0, 1'b0);
    lk(32'h118, 1'b0, 32'h0, 1'b0);

    // reset in flush cycle 3; set 7 entry only reset can clear
    up(32'h11C, 32'hABC, 1'b1);
    lk(32'h11C, 1'b1, 32'hABC, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk_fl(1'b1);
    up(32'h0, 32'h0, 1'b0);
    up(32'h0, 32'h0, 1'b0);
    chk_fl(1'b1);
    pulse_reset();
    chk_fl(1'b0);
    lk(32'h11C, 1'b0, 32'h0, 1'b0);
    chk_fl(1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/btb_assoc_file.md
# btb_assoc_file

Parametrised set-associative branch-target-buffer storage, successor to the fixed 8-set, single-wide BTB array. The fetch stage sends lookups, and the execute stage sends resolved-branch updates. Each entry holds a valid bit, a tag, a target and a 2-bit taken counter, and each set has tree-PLRU replacement state. The block adds async clear, registered lookup with same-cycle update forwarding, a valid/ready update port, and a multi-cycle flush sequencer.

## Interface
- SETS, 8, number of sets; power of two, at least 2; IDX_W = log2(SETS)
- WAYS, 2, associativity; one of 1, 2, 4
- PC_W, 32, PC width; pc[1:0] ignored; index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]
- TARGET_W, 32, stored target width
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- lookup_valid  in  1  lookup request this cycle
- lookup_pc  in  PC_W  fetch PC to look up
- pred_valid  out  1  registered echo of lookup_valid
- pred_hit  out  1  tag match in a valid way
- pred_target  out  TARGET_W  target of the hit way; 0 on miss
- pred_taken  out  1  MSB of the hit way's counter; 0 on miss
- upd_valid  in  1  update request
- upd_ready  out  1  update accepted when upd_valid && upd_ready
- upd_pc  in  PC_W  resolved branch PC
- upd_target  in  TARGET_W  resolved target
- upd_taken  in  1  resolved direction
- flush_req  in  1  start a full-array invalidate
- flush_busy  out  1  flush in progress

## Operation
- **Reset** (async, rst_n = 0):
  - all valid bits, counters and PLRU bits cleared to 0.
  - pred_valid, pred_hit, pred_target and pred_taken = 0; flush_busy = 0.
  - state = IDLE. upd_ready = 1 once rst_n deasserts.
  - Tags and targets need not be cleared.
- **States:**
  - IDLE → FLUSH on flush_req.
  - FLUSH → IDLE after the cycle that clears set SETS-1.
  - flush_req while in FLUSH is ignored.
- **FLUSH:**
  - one set per cycle, index 0 to SETS-1, clears all ways' valid bits and that set's PLRU bits.
  - flush_busy = 1 and upd_ready = 0.
  - Lookups sampled during FLUSH return pred_hit = 0.
- **Update, hit** (tag matches in valid way w):
  - target ← upd_target.
  - counter saturating +1 if upd_taken, otherwise −1, in range 0..3.
  - PLRU touched with w.
- **Update, miss with upd_taken = 1:**
  - victim = lowest-index invalid way; if none, the PLRU victim.
  - Victim is written valid = 1, new tag, target, counter = 2'b10; PLRU touched with the victim.
- **Update, miss with upd_taken = 0:** no state change.
- **PLRU:** only updates touch it; lookups never do.
  - WAYS = 1: no bits.
  - WAYS = 2: one bit b = victim way. Touching w sets b = ~w.
  - WAYS = 4: bits b0, b1, b2.
    - Victim = b0 ? (b2 ? 3 : 2) : (b1 ? 1 : 0).
    - Touching w sets b0 = ~w[1]; then b1 = ~w[0] if w[1] = 0, else b2 = ~w[0].
- **Lookup:**
  - On a multi-way tag match (illegal), the lowest way wins.
  - Update hits never allocate a second copy, so a multi-way match must not occur.

## Timing
- **Lookup latency:** 1 cycle. Lookup sampled at edge N; pred_* valid in cycle N+1 and held until the next edge.
- **Forwarding:** an update accepted in the same cycle as a lookup to the same set is visible to that lookup (write-first).
  - Example: an allocation and a lookup of the same PC in one cycle give pred_hit = 1 with the new target.
- **Updates:** commit at the edge where upd_valid && upd_ready; one per cycle; upd_ready depends only on state.
- **Flush duration:** flush_req sampled at edge N. flush_busy is 1 from cycle N+1 through cycle N+SETS, and 0 in cycle N+SETS+1.
- **Update during flush_req:** an update accepted in cycle N still commits, and the flush then clears it.
- **Reset mid-flush:** immediate return to IDLE with the array cleared.

## Test plan
- **Reset:** assert rst_n = 0 mid-run → all pred_* = 0, flush_busy = 0, upd_ready = 1 after release; lookup of any PC → pred_hit = 0.
- **Allocate and lookup:** update pc 0x100, target 0x200, taken. Next-cycle lookup 0x100 → pred_hit = 1, pred_target = 0x200, pred_taken = 1.
  - Same PC with upd_taken = 0 twice → pred_taken = 0, counter 0.
  - Counter saturates at 0 and at 3.
- **Replacement** (WAYS = 2, SETS = 8): allocate A, B, C with the same index, touching A between B and C → C evicts B; A still hits.
  - WAYS = 4: check the victim sequence 0, 1, 2, 3, then the PLRU order.
- **Forwarding:** update and lookup of the same new PC in one cycle → pred_hit = 1 next cycle.
  - Lookup of a different set in that cycle is unaffected.
- **Not-taken miss:** update of an absent PC with upd_taken = 0 → no allocation; a later lookup misses.
- **Flush:** flush_req with SETS = 8 → flush_busy high exactly 8 cycles and upd_ready low throughout; all lookups miss afterwards.
  - rst_n pulsed at flush cycle 3 → immediate IDLE.
  - flush_req repeated during FLUSH → no extension.
